// File: rtl/logic_gate_pipe_pkg.sv
// Shared definitions for the gate library: two-input function op codes and
// the occupancy states of the 2-entry skid buffer.
package logic_gate_pipe_pkg;

   localparam logic [2:0] OP_NAND = 3'b000;
   localparam logic [2:0] OP_NOR  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_NOTA = 3'b110;
   localparam logic [2:0] OP_BUF  = 3'b111;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/logic_gate_pipe_skid_buf.sv
// Generic 2-entry valid/ready FIFO: head is the output register, tail is the
// skid slot that absorbs one beat while the consumer stalls.
module logic_gate_pipe_skid_buf
   import logic_gate_pipe_pkg::*;
#(
   parameter int            DW      = 8,
   parameter logic [DW-1:0] RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output buf_state_t    state
);

   // Handshake: a beat moves on any edge where its valid and ready are both
   // high; the producer sees ready only while the buffer is not full.
   buf_state_t    state_q, state_d;
   logic [DW-1:0] head_q, tail_q;
   logic          push, pop;

   assign push = in_valid && (state_q != BUF_FULL);
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= BUF_EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BUF_EMPTY: if (push) state_d = BUF_ONE;
         BUF_ONE: begin
            if (push && !pop)      state_d = BUF_FULL;
            else if (pop && !push) state_d = BUF_EMPTY;
         end
         BUF_FULL:  if (pop) state_d = BUF_ONE;
         default:   state_d = BUF_EMPTY;
      endcase
   end

   always_comb begin
      out_valid = (state_q != BUF_EMPTY);
      out_data  = head_q;
      state     = state_q;
   end

   // Head keeps its last value when drained, so the output holds while empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= RST_VAL;
         tail_q <= RST_VAL;
      end else if (state_q == BUF_FULL) begin
         if (pop) head_q <= tail_q;
      end else if (push && (state_q == BUF_EMPTY || pop)) begin
         head_q <= in_data;
      end else if (push) begin
         tail_q <= in_data;
      end
   end

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined bitwise two-input gate: op decode and result flags at acceptance,
// a 2-entry skid buffer on the output, and a saturating delivered-beat count.
module logic_gate_pipe
   import logic_gate_pipe_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               res_zero,
   output logic               res_ones,
   output logic [COUNT_W-1:0] op_count
);

   localparam int                 DW      = WIDTH + 2;
   localparam logic [DW-1:0]      RST_VAL = {1'b0, 1'b1, {WIDTH{1'b0}}};
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] f;
   logic             f_zero, f_ones;
   logic [DW-1:0]    buf_out;
   buf_state_t       buf_state;

   always_comb begin
      f = a;
      case (op)
         OP_NAND: f = ~(a & b);
         OP_NOR:  f = ~(a | b);
         OP_AND:  f = a & b;
         OP_OR:   f = a | b;
         OP_XOR:  f = a ^ b;
         OP_XNOR: f = ~(a ^ b);
         OP_NOTA: f = ~a;
         OP_BUF:  f = a;
         default: f = a;
      endcase
      f_zero = (f == '0);
      f_ones = (f == '1);
   end

   // Ready depends only on registered occupancy and reset, never on out_ready.
   assign in_ready = !rst && (buf_state != BUF_FULL);

   logic_gate_pipe_skid_buf #(
      .DW      (DW),
      .RST_VAL (RST_VAL)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid && !rst),
      .in_data   ({f_ones, f_zero, f}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (buf_out),
      .state     (buf_state)
   );

   assign {res_ones, res_zero, result} = buf_out;

   always_ff @(posedge clk) begin
      if (rst)
         op_count <= '0;
      else if (out_valid && out_ready && (op_count != CNT_MAX))
         op_count <= op_count + COUNT_W'(1);
   end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: directed and random traffic against a
// truth-table reference model with an expected-result queue.
module tb_logic_gate_pipe;

   localparam int W  = 8;
   localparam int CW = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic [2:0]     op = '0;

   logic           in_ready, out_valid, res_zero, res_ones;
   logic [W-1:0]   result;
   logic [CW-1:0]  op_count;
   logic           in_ready2, out_valid2, res_zero2, res_ones2;
   logic [W-1:0]   result2;
   logic [1:0]     op_count2;

   logic           s_in_ready, s_out_valid, s_in_ready2, s_out_valid2;
   logic [W+1:0]   s_data, s_data2;
   logic [CW-1:0]  s_count;
   logic [1:0]     s_count2;

   int             checks = 0;
   int             failures = 0;
   logic [W+1:0]   exp_q[$];

   logic_gate_pipe #(.WIDTH(W), .COUNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .res_zero(res_zero), .res_ones(res_ones),
      .op_count(op_count)
   );

   logic_gate_pipe #(.WIDTH(W), .COUNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
      .result(result2), .res_zero(res_zero2), .res_ones(res_ones2),
      .op_count(op_count2)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Truth table per op, indexed by {a_bit, b_bit}.
   function automatic logic [3:0] truth(input logic [2:0] f);
      case (f)
         3'd0: truth = 4'b0111;
         3'd1: truth = 4'b0001;
         3'd2: truth = 4'b1000;
         3'd3: truth = 4'b1110;
         3'd4: truth = 4'b0110;
         3'd5: truth = 4'b1001;
         3'd6: truth = 4'b0011;
         default: truth = 4'b1100;
      endcase
   endfunction

   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic [2:0] mop);
      logic [3:0]   t;
      logic [W-1:0] r;
      t = truth(mop);
      for (int i = 0; i < W; i++) r[i] = t[{ma[i], mb[i]}];
      model = {(int'(r) == (1 << W) - 1), (int'(r) == 0), r};
   endfunction

   // Drive one cycle of inputs, sample outputs mid-cycle, then advance past the edge.
   task automatic tick(input logic iv, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [2:0] to_v, input logic ordy);
      in_valid = iv; a = ta; b = tb_v; op = to_v; out_ready = ordy;
      @(negedge clk);
      s_in_ready   = in_ready;
      s_out_valid  = out_valid;
      s_data       = {res_ones, res_zero, result};
      s_count      = op_count;
      s_in_ready2  = in_ready2;
      s_out_valid2 = out_valid2;
      s_data2      = {res_ones2, res_zero2, result2};
      s_count2     = op_count2;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      tick(1'b1, 8'hA5, 8'h5A, 3'd4, 1'b1);
      checks++;
      if (s_in_ready !== 1'b0) begin
         failures++; $display("FAIL reset_in_ready: got %b want 0", s_in_ready);
      end
      checks++;
      if (s_out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid: got %b want 0", s_out_valid);
      end
      checks++;
      if (s_data !== {1'b0, 1'b1, 8'h00}) begin
         failures++; $display("FAIL reset_data: got %h want %h", s_data, {1'b0, 1'b1, 8'h00});
      end
      checks++;
      if (s_count !== '0) begin
         failures++; $display("FAIL reset_count: got %0d want 0", s_count);
      end
      rst = 1'b0;
      tick(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      checks++;
      if (s_in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_release_ready: got %b want 1", s_in_ready);
      end
      checks++;
      if (s_out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_dropped_beat: out_valid got %b want 0", s_out_valid);
      end
   endtask

   task automatic test_ops();
      logic [W-1:0] want [8];
      want = '{8'h3F, 8'h03, 8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
      do_reset();
      for (int k = 0; k <= 8; k++) begin
         tick(k < 8, 8'hF0, 8'hCC, 3'(k), 1'b1);
         if (k < 8) begin
            checks++;
            if (s_in_ready !== 1'b1) begin
               failures++; $display("FAIL ops_in_ready[%0d]: got %b want 1", k, s_in_ready);
            end
         end
         if (k > 0) begin
            checks++;
            if (s_out_valid !== 1'b1 || s_data[W-1:0] !== want[k-1]) begin
               failures++;
               $display("FAIL ops_result[%0d]: got valid=%b res=%h want valid=1 res=%h",
                        k - 1, s_out_valid, s_data[W-1:0], want[k-1]);
            end
         end
      end
      tick(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      checks++;
      if (s_count !== CW'(8)) begin
         failures++; $display("FAIL ops_count: got %0d want 8", s_count);
      end
      checks++;
      if (s_out_valid !== 1'b0 || s_data[W-1:0] !== 8'hF0) begin
         failures++;
         $display("FAIL ops_empty_hold: got valid=%b res=%h want valid=0 res=f0",
                  s_out_valid, s_data[W-1:0]);
      end
   endtask

   task automatic test_flags();
      do_reset();
      tick(1'b1, 8'hFF, 8'hFF, 3'd0, 1'b1);
      tick(1'b1, 8'h00, 8'h00, 3'd1, 1'b1);
      checks++;
      if (s_out_valid !== 1'b1 || s_data !== {1'b0, 1'b1, 8'h00}) begin
         failures++; $display("FAIL flags_zero: got v=%b data=%h want v=1 data=%h",
                              s_out_valid, s_data, {1'b0, 1'b1, 8'h00});
      end
      tick(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      checks++;
      if (s_out_valid !== 1'b1 || s_data !== {1'b1, 1'b0, 8'hFF}) begin
         failures++; $display("FAIL flags_ones: got v=%b data=%h want v=1 data=%h",
                              s_out_valid, s_data, {1'b1, 1'b0, 8'hFF});
      end
   endtask

   task automatic test_back_pressure();
      logic [W+1:0] e1, e2, e3;
      e1 = model(8'h11, 8'h22, 3'd4);
      e2 = model(8'h0F, 8'hF0, 3'd2);
      e3 = model(8'hAA, 8'h0F, 3'd3);
      do_reset();
      tick(1'b1, 8'h11, 8'h22, 3'd4, 1'b0);
      checks++;
      if (s_in_ready !== 1'b1) begin
         failures++; $display("FAIL bp_first_ready: got %b want 1", s_in_ready);
      end
      tick(1'b1, 8'h0F, 8'hF0, 3'd2, 1'b0);
      checks++;
      if (s_in_ready !== 1'b1 || s_out_valid !== 1'b1 || s_data !== e1) begin
         failures++; $display("FAIL bp_second: got rdy=%b v=%b data=%h want rdy=1 v=1 data=%h",
                              s_in_ready, s_out_valid, s_data, e1);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 8'hAA, 8'h0F, 3'd3, 1'b0);
         checks++;
         if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1 || s_data !== e1) begin
            failures++; $display("FAIL bp_stall[%0d]: got rdy=%b v=%b data=%h want rdy=0 v=1 data=%h",
                                 i, s_in_ready, s_out_valid, s_data, e1);
         end
      end
      tick(1'b1, 8'hAA, 8'h0F, 3'd3, 1'b1);
      checks++;
      if (s_in_ready !== 1'b0 || s_data !== e1) begin
         failures++; $display("FAIL bp_drain1: got rdy=%b data=%h want rdy=0 data=%h",
                              s_in_ready, s_data, e1);
      end
      tick(1'b1, 8'hAA, 8'h0F, 3'd3, 1'b1);
      checks++;
      if (s_in_ready !== 1'b1 || s_out_valid !== 1'b1 || s_data !== e2) begin
         failures++; $display("FAIL bp_drain2: got rdy=%b v=%b data=%h want rdy=1 v=1 data=%h",
                              s_in_ready, s_out_valid, s_data, e2);
      end
      tick(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      checks++;
      if (s_out_valid !== 1'b1 || s_data !== e3) begin
         failures++; $display("FAIL bp_third: got v=%b data=%h want v=1 data=%h",
                              s_out_valid, s_data, e3);
      end
      tick(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      checks++;
      if (s_out_valid !== 1'b0 || s_count !== CW'(3)) begin
         failures++; $display("FAIL bp_done: got v=%b count=%0d want v=0 count=3",
                              s_out_valid, s_count);
      end
   endtask

   task automatic test_stream();
      int           sent, recv, cyc;
      logic         iv, ordy;
      logic [W-1:0] ta, tbv;
      logic [2:0]   to;
      logic [W+1:0] e;
      sent = 0; recv = 0; cyc = 0;
      do_reset();
      while ((sent < 100 || exp_q.size() > 0) && cyc < 2000) begin
         iv   = (sent < 100) && 1'($urandom_range(0, 1));
         ta   = W'($urandom);
         tbv  = W'($urandom);
         to   = 3'($urandom_range(0, 7));
         ordy = 1'($urandom_range(0, 1));
         tick(iv, ta, tbv, to, ordy);
         checks++;
         if (s_in_ready !== (exp_q.size() < 2) || s_out_valid !== (exp_q.size() > 0)) begin
            failures++; $display("FAIL stream_occupancy: got rdy=%b v=%b with %0d queued",
                                 s_in_ready, s_out_valid, exp_q.size());
         end
         checks++;
         if (s_count !== CW'(recv)) begin
            failures++; $display("FAIL stream_count: got %0d want %0d", s_count, recv);
         end
         if (s_out_valid && ordy) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL stream_spurious: got data=%h with empty model", s_data);
            end else begin
               e = exp_q.pop_front();
               if (s_data !== e) begin
                  failures++; $display("FAIL stream_data[%0d]: got %h want %h", recv, s_data, e);
               end
            end
            recv++;
         end
         if (iv && s_in_ready) begin
            exp_q.push_back(model(ta, tbv, to));
            sent++;
         end
         cyc++;
      end
      checks++;
      if (sent != 100 || recv != 100) begin
         failures++; $display("FAIL stream_complete: got sent=%0d recv=%0d want 100/100", sent, recv);
      end
      tick(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      checks++;
      if (s_count !== CW'(100)) begin
         failures++; $display("FAIL stream_final_count: got %0d want 100", s_count);
      end
   endtask

   task automatic test_saturate();
      int           done;
      logic [W-1:0] ta, tbv;
      logic [2:0]   to;
      logic [W+1:0] e;
      done = 0;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         ta  = W'($urandom);
         tbv = W'($urandom);
         to  = 3'($urandom_range(0, 7));
         tick(k < 5, ta, tbv, to, 1'b1);
         checks++;
         if (s_count2 !== 2'((done > 3) ? 3 : done) || s_count !== CW'(done)) begin
            failures++; $display("FAIL sat_count[%0d]: got c2=%0d c16=%0d want c2=%0d c16=%0d",
                                 k, s_count2, s_count, (done > 3) ? 3 : done, done);
         end
         checks++;
         if (s_in_ready2 !== 1'b1 || s_out_valid2 !== (exp_q.size() > 0)) begin
            failures++; $display("FAIL sat_handshake[%0d]: got rdy=%b v=%b with %0d queued",
                                 k, s_in_ready2, s_out_valid2, exp_q.size());
         end
         if (s_out_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (s_data2 !== e || s_data !== e) begin
               failures++; $display("FAIL sat_data[%0d]: got %h/%h want %h", k, s_data2, s_data, e);
            end
            done++;
         end
         if (k < 5 && s_in_ready) exp_q.push_back(model(ta, tbv, to));
      end
      checks++;
      if (done != 5) begin
         failures++; $display("FAIL sat_transfers: got %0d want 5", done);
      end
   endtask

   task automatic test_reset_stall();
      logic [W+1:0] e;
      do_reset();
      tick(1'b1, 8'h12, 8'h34, 3'd3, 1'b1);
      tick(1'b1, 8'h56, 8'h78, 3'd4, 1'b1);
      tick(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      tick(1'b1, 8'h9A, 8'hBC, 3'd3, 1'b0);
      tick(1'b1, 8'hDE, 8'hF0, 3'd5, 1'b0);
      tick(1'b1, 8'h13, 8'h57, 3'd2, 1'b0);
      checks++;
      if (s_in_ready !== 1'b0 || s_count !== CW'(2)) begin
         failures++; $display("FAIL rst_stall_full: got rdy=%b count=%0d want rdy=0 count=2",
                              s_in_ready, s_count);
      end
      rst = 1'b1;
      tick(1'b1, 8'h13, 8'h57, 3'd2, 1'b0);
      checks++;
      if (s_in_ready !== 1'b0) begin
         failures++; $display("FAIL rst_stall_ready_low: got %b want 0", s_in_ready);
      end
      rst = 1'b0;
      exp_q.delete();
      e = model(8'hC3, 8'h5A, 3'd1);
      tick(1'b1, 8'hC3, 8'h5A, 3'd1, 1'b1);
      checks++;
      if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_count !== '0 ||
          s_data !== {1'b0, 1'b1, 8'h00}) begin
         failures++; $display("FAIL rst_stall_state: got v=%b rdy=%b count=%0d data=%h want v=0 rdy=1 count=0 data=100",
                              s_out_valid, s_in_ready, s_count, s_data);
      end
      tick(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      checks++;
      if (s_out_valid !== 1'b1 || s_data !== e) begin
         failures++; $display("FAIL rst_stall_fresh: got v=%b data=%h want v=1 data=%h",
                              s_out_valid, s_data, e);
      end
      tick(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      checks++;
      if (s_count !== CW'(1)) begin
         failures++; $display("FAIL rst_stall_count: got %0d want 1", s_count);
      end
   endtask

   initial begin
      test_reset();
      test_ops();
      test_flags();
      test_back_pressure();
      test_stream();
      test_saturate();
      test_reset_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
